// File: rtl/iformat_exec.sv
// Multi-cycle sequencer for one D-form ALU instruction against a single-port regfile:
// read rs, compute with the immediate, write rt, then pulse done.
module iformat_exec #(
  parameter logic [5:0] OP_ADDI  = 6'd14,
  parameter logic [5:0] OP_ADDIS = 6'd15,
  parameter logic [5:0] OP_ANDI  = 6'd28,
  parameter logic [5:0] OP_ORI   = 6'd24,
  parameter logic [5:0] OP_XORI  = 6'd26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr,
  output logic [4:0]  rf_address,
  output logic        rf_en_write,
  output logic [31:0] rf_idata,
  input  logic [31:0] rf_data,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] result
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } dform_t;

  state_t      state, state_nx;
  dform_t      iq;
  logic [31:0] alu;
  logic        accept, legal_in;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIS) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_XORI);
  endfunction

  assign accept   = (state == IDLE) && start;
  assign legal_in = is_legal(instr[31:26]);

  // rf_data is valid during CAPT; result is registered at the end of that cycle
  always_comb begin
    alu = '0;
    case (iq.op)
      OP_ADDI:  alu = rf_data + {{16{iq.imm[15]}}, iq.imm};
      OP_ADDIS: alu = rf_data + {iq.imm, 16'h0000};
      OP_ANDI:  alu = rf_data & {16'h0000, iq.imm};
      OP_ORI:   alu = rf_data | {16'h0000, iq.imm};
      OP_XORI:  alu = rf_data ^ {16'h0000, iq.imm};
      default:  alu = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      iq      <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        iq      <= instr;
        illegal <= !legal_in;
        result  <= '0;
      end
      if (state == CAPT) result <= alu;
    end
  end

  // Port drives decode straight from state so async reset kills a write instantly
  always_comb begin
    state_nx    = state;
    rf_address  = '0;
    rf_en_write = 1'b0;
    rf_idata    = '0;
    case (state)
      IDLE:  if (start) state_nx = legal_in ? READ : DONE;
      READ:  begin rf_address = iq.rs; state_nx = CAPT; end
      CAPT:  begin rf_address = iq.rs; state_nx = WRITE; end
      WRITE: begin
        rf_address  = iq.rt;
        rf_en_write = 1'b1;
        rf_idata    = result;
        state_nx    = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_iformat_exec.sv
// Directed bench: behavioural regfile with a bench-side write/read mux, scoreboard of
// expected completions popped at each done pulse.
module tb_iformat_exec;

  logic        clock, reset, start;
  logic [31:0] instr;
  logic [4:0]  rf_address;
  logic        rf_en_write;
  logic [31:0] rf_idata, rf_data;
  logic        busy, done, illegal;
  logic [31:0] result;

  iformat_exec dut (
    .clock(clock), .reset(reset), .start(start), .instr(instr),
    .rf_address(rf_address), .rf_en_write(rf_en_write), .rf_idata(rf_idata),
    .rf_data(rf_data), .busy(busy), .done(done), .illegal(illegal), .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // regfile model; tb_sel hands the port to the bench for preload/readback
  logic        tb_sel, tb_we;
  logic [4:0]  tb_addr;
  logic [31:0] tb_wd;
  logic [31:0] mem [32];
  logic [4:0]  m_addr;
  logic        m_we;
  logic [31:0] m_wd;

  assign m_addr = tb_sel ? tb_addr : rf_address;
  assign m_we   = tb_sel ? tb_we   : rf_en_write;
  assign m_wd   = tb_sel ? tb_wd   : rf_idata;

  always @(posedge clock) begin
    if (m_we) mem[m_addr] <= m_wd;
    rf_data <= mem[m_addr];
  end

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic [4:0]  rt;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_sel = 1'b1; tb_we = 1'b1; tb_addr = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0; tb_sel = 1'b0;
  endtask

  task automatic readback(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clock);
    tb_sel = 1'b1; tb_we = 1'b0; tb_addr = a;
    @(negedge clock);
    chk(tag, rf_data, exp);
    tb_sel = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] exp_res,
                       input logic exp_ill, input logic repulse);
    exp_t        e;
    int          lat, wcnt;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    e.res = exp_res; e.ill = exp_ill; e.rt = ins[20:16]; e.lat = exp_ill ? 1 : 4;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1; instr = ins;
    @(posedge clock);
    #1 start = 1'b0; instr = $urandom;
    lat = 0; wcnt = 0; waddr = '0; wdata = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      lat = k;
      if (k == 1) chk("busy", {31'd0, busy}, 32'd1);
      if (rf_en_write) begin wcnt++; waddr = rf_address; wdata = rf_idata; end
      if (repulse && k == 1) begin start = 1'b1; instr = 32'h7029000F; end
      if (repulse && k == 2) start = 1'b0;
      if (done) break;
    end
    e = sb.pop_front();
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
    chk("write_count", 32'(wcnt), e.ill ? 32'd0 : 32'd1);
    if (!e.ill) begin
      chk("write_addr", {27'd0, waddr}, {27'd0, e.rt});
      chk("write_data", wdata, e.res);
      chk("result", result, e.res);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset = 1'b0; start = 1'b0; instr = '0;
    tb_sel = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wd = '0;
    #3;
    chk("rst_addr",   {27'd0, rf_address}, 32'd0);
    chk("rst_we",     {31'd0, rf_en_write}, 32'd0);
    chk("rst_idata",  rf_idata, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_illegal",{31'd0, illegal}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    preload(5'd1, 32'd212);
    issue(32'h3822FFFF, 32'd211, 1'b0, 1'b0);
    readback("r2_addi", 5'd2, 32'd211);
    issue(32'h3C230001, 32'h000100D4, 1'b0, 1'b0);
    readback("r3_addis", 5'd3, 32'h000100D4);
    issue(32'h702400F0, 32'h000000D0, 1'b0, 1'b0);
    readback("r4_andi", 5'd4, 32'h000000D0);
    issue(32'h60250F00, 32'h00000FD4, 1'b0, 1'b0);
    readback("r5_ori", 5'd5, 32'h00000FD4);
    issue(32'h68260FFF, 32'h00000F2B, 1'b0, 1'b0);
    readback("r6_xori", 5'd6, 32'h00000F2B);

    issue(32'h00000000, 32'd0, 1'b1, 1'b0);

    // rs == rt reads the old value before the write lands
    preload(5'd9, 32'd10);
    issue(32'h39290003, 32'd13, 1'b0, 1'b0);
    readback("r9_same", 5'd9, 32'd13);

    preload(5'd1, 32'hFFFFFFFF);
    issue(32'h38280001, 32'd0, 1'b0, 1'b0);
    readback("r8_ovf", 5'd8, 32'd0);

    // second start during READ must be ignored
    preload(5'd1, 32'd212);
    preload(5'd2, 32'd0);
    issue(32'h3822FFFF, 32'd211, 1'b0, 1'b1);
    readback("r2_repulse", 5'd2, 32'd211);
    @(negedge clock);
    chk("idle_after_repulse", {31'd0, busy}, 32'd0);

    // reset landing inside WRITE
    preload(5'd7, 32'h00000055);
    @(negedge clock);
    start = 1'b1; instr = 32'h38270005;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    chk("we_before_rst", {31'd0, rf_en_write}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we",     {31'd0, rf_en_write}, 32'd0);
    chk("mid_rst_addr",   {27'd0, rf_address}, 32'd0);
    chk("mid_rst_idata",  rf_idata, 32'd0);
    chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
    chk("mid_rst_done",   {31'd0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    readback("r7_untouched", 5'd7, 32'h00000055);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iformat_exec.md
Name: iformat_exec

Overview:
Sequencer that executes one uPower I-format (D-form) ALU instruction against the single-port register file (regfile). It is the initiator on the regfile port: it reads the source register, computes with the immediate, and writes the destination register, reporting completion to the issuing logic.
Field split: opcode = instr[31:26], rs (source) = instr[25:21], rt (destination) = instr[20:16], imm = instr[15:0].

Parameters:
OP_ADDI, 14, opcode for rt = rs + sext(imm)
OP_ADDIS, 15, opcode for rt = rs + (imm << 16)
OP_ANDI, 28, opcode for rt = rs & zext(imm)
OP_ORI, 24, opcode for rt = rs | zext(imm)
OP_XORI, 26, opcode for rt = rs ^ zext(imm)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
start  in  1  issue request; sampled only in IDLE
instr  in  32  instruction word; latched when start is accepted
rf_address  out  5  regfile address
rf_en_write  out  1  regfile write enable
rf_idata  out  32  regfile write data
rf_data  in  32  regfile read data (registered by regfile one edge after the address is presented)
busy  out  1  high from the cycle after accept until done cycle inclusive
done  out  1  one-cycle completion pulse
illegal  out  1  valid with done; opcode not supported
result  out  32  value written to rt; held until next accept

Behaviour:
- Reset (reset = 0, async): state = IDLE. rf_address, rf_en_write, rf_idata, busy, done, illegal and result are all 0. The instr latch is cleared.
- State machine: IDLE -> READ -> CAPT -> WRITE -> DONE -> IDLE.
- IDLE: rf_en_write = 0. If start = 1, latch instr and decode the opcode.
  - Supported opcode: go to READ.
  - Unsupported opcode: go to DONE with illegal = 1; the regfile is never accessed.
- READ (1 cycle): rf_address = rs, rf_en_write = 0. The regfile captures the read at the closing edge.
- CAPT (1 cycle): rf_address = rs is held. At the closing edge, compute result from rf_data and the latched imm.
- WRITE (1 cycle): rf_address = rt, rf_en_write = 1, rf_idata = result. This is the only state in which rf_en_write = 1.
- DONE (1 cycle): done = 1, busy = 1. rf_en_write = 0 and rf_address = 0.
- Latency: start accepted at edge N; done is high in cycle N+4 for supported opcodes and in cycle N+1 for illegal ones. Back-to-back issue is possible from the cycle after done.
- Arithmetic: 32-bit, modulo 2^32; overflow and carry are discarded. sext replicates imm[15]; zext pads with zeros.
- rs == rt: the read completes before the write, so rt receives f(old rs).
- rs or rt = 0: register 0 is an ordinary register; there is no zero-register special case.
- start while busy: ignored; instr is not re-latched.
- Reset mid-operation: rf_en_write drops to 0 immediately and asynchronously. No partial or late write occurs, and no done pulse is produced.
- illegal is cleared on the next accept.

Test Plan:
- Sign-extended add: preload r1 = 212 through the bench-side write mux, then start with instr = 0x3822FFFF (addi rs=1 rt=2 imm=-1).
  -> done 4 cycles after accept; result = 211; readback r2 = 211; exactly one rf_en_write cycle.
- Shifted add: r1 = 212, instr = 0x3C230001 (addis rt=3).
  -> result = 0x000100D4 (65748); r3 = 65748.
- Logical immediates:
  - andi 0x702400F0 (rt=4) -> r4 = 0xD0.
  - ori 0x60250F00 (rt=5) -> r5 = 0x0FD4.
  - xori 0x68260FFF (rt=6) -> r6 = 0x0F2B.
  - All use r1 = 212 and zero extension.
- Illegal opcode and overflow:
  - instr = 0x00000000 -> done 1 cycle after accept, illegal = 1, rf_en_write never asserted.
  - Overflow: r1 = 0xFFFFFFFF with addi imm=1 -> result 0.
- Busy/reset robustness:
  - start pulsed again during READ with a different instr -> ignored, the original result is written.
  - reset asserted low during WRITE -> rf_en_write falls immediately, all outputs 0, no done pulse.
